// File: rtl/data_memory_sized.sv
// data_memory_sized: big-endian byte-addressable data memory with registered loads,
// alignment/range checking and a reset-time initialisation sequencer.
module data_memory_sized #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 64,
    parameter int INIT_MODE   = 1
) (
    input  logic              clk,
    input  logic              startin_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              addr_err,
    output logic              busy
);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WW    = $clog2(WORDS);
    localparam int IW    = WW + 2;
    localparam int AW1   = ADDR_W + 1;
    typedef enum logic {INIT, READY} state_t;
    state_t            state_q;
    logic [WW-1:0]     cnt_q;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, addr_err_q;
    logic [7:0]        mem_q [DEPTH_BYTES];
    logic [IW-1:0]     a0, a1, a2, a3, init_base;
    logic [2:0]        nbytes;
    logic [AW1-1:0]    last_addr;
    logic              aligned, valid, ready, ld, st, bad, sgn, cnt_last;
    logic [31:0]       init_word;
    // Accesses are aligned when valid, so OR-ing the low bits gives the following byte addresses.
    assign a0        = address[IW-1:0];
    assign a1        = a0 | IW'(1);
    assign a2        = a0 | IW'(2);
    assign a3        = a0 | IW'(3);
    assign nbytes    = size == 2'b00 ? 3'd1 : size == 2'b01 ? 3'd2 : 3'd4;
    assign last_addr = {1'b0, address} + AW1'(nbytes) - AW1'(1);
    assign aligned   = size == 2'b00 || (size == 2'b01 && !address[0]) || (size == 2'b10 && address[1:0] == 2'b00);
    assign valid     = size != 2'b11 && aligned && last_addr < AW1'(DEPTH_BYTES);
    assign ready     = state_q == READY && startin_n;
    assign ld        = ready && mem_read && valid;
    assign st        = ready && mem_write && valid;
    assign bad       = ready && (mem_read || mem_write) && !valid;
    assign sgn       = !load_unsigned && mem_q[a0][7];
    assign read_data_d = size == 2'b00 ? {{24{sgn}}, mem_q[a0]} :
                         size == 2'b01 ? {{16{sgn}}, mem_q[a0], mem_q[a1]} :
                                         {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
    assign cnt_last  = cnt_q == WW'(WORDS - 1);
    assign init_base = {cnt_q, 2'b00};
    assign init_word = INIT_MODE == 0 ? 32'h0 : cnt_q == '0 ? 32'hFFFF_FFFF : cnt_q[0] ? 32'h2 : 32'h1;
    // Memory is read combinationally before the edge, so a same-cycle store is read-first.
    always_ff @(posedge clk) begin
        if (startin_n && state_q == INIT) begin
            for (int k = 0; k < 4; k++) mem_q[init_base | IW'(k)] <= init_word[31-8*k -: 8];
        end else if (st) begin
            mem_q[a0] <= size == 2'b00 ? write_data[7:0] : size == 2'b01 ? write_data[15:8] : write_data[31:24];
            if (size != 2'b00) mem_q[a1] <= size == 2'b01 ? write_data[7:0] : write_data[23:16];
            if (size == 2'b10) begin
                mem_q[a2] <= write_data[15:8];
                mem_q[a3] <= write_data[7:0];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!startin_n) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            read_valid_q <= ld;
            addr_err_q   <= bad;
            if (ld) read_data_q <= read_data_d;
            else if (bad) read_data_q <= '0;
            if (state_q == INIT) begin
                cnt_q <= cnt_last ? '0 : cnt_q + WW'(1);
                if (cnt_last) state_q <= READY;
            end
        end
    end
    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign addr_err   = addr_err_q;
    assign busy       = state_q == INIT;
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: vector table plus reset sequences, checked through an expectation queue.
module tb_data_memory_sized;
    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, R = 2'd3;
    logic        clk = 1'b0;
    logic        startin_n = 1'b0, mem_write = 1'b0, mem_read = 1'b0, load_unsigned = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [1:0]  size = '0;
    logic [31:0] read_data;
    logic        read_valid, addr_err, busy;
    always #5 clk = ~clk;
    data_memory_sized dut (
        .clk(clk), .startin_n(startin_n), .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .size(size), .load_unsigned(load_unsigned),
        .read_data(read_data), .read_valid(read_valid), .addr_err(addr_err), .busy(busy)
    );
    typedef struct { logic rv; logic err; logic bsy; logic [31:0] data; int id; } exp_t;
    typedef struct {
        logic rd; logic wr; logic [31:0] addr; logic [1:0] sz; logic lu; logic [31:0] wd;
        logic rv; logic err; logic [31:0] data;
    } vec_t;
    exp_t        sb[$];
    exp_t        m;
    vec_t        vec[26];
    int          checks = 0, failures = 0, init_left = 0, seq_id = 0;
    logic [31:0] last_data = '0;
    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
        end
    endtask
    // Expectations follow the request: ignored while reset/init runs, else as the caller predicts.
    task automatic drive(input logic rst_n, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] sz, input logic lu, input logic [31:0] wd,
                         input logic rv, input logic err, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        startin_n = rst_n; mem_read = rd; mem_write = wr; address = a;
        size = sz; load_unsigned = lu; write_data = wd;
        if (!rst_n) begin
            init_left = 16; e.bsy = 1'b1; e.rv = 1'b0; e.err = 1'b0; last_data = '0;
        end else if (init_left > 0) begin
            init_left--; e.bsy = init_left > 0; e.rv = 1'b0; e.err = 1'b0;
        end else begin
            e.bsy = 1'b0; e.rv = rv; e.err = err;
            if (rv) last_data = d;
            else if (err) last_data = '0;
        end
        e.data = last_data;
        e.id = seq_id++;
        sb.push_back(e);
    endtask
    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'd0, B, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask
    task automatic rd_word(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, 1'b0, a, W, 1'b0, 32'd0, 1'b1, 1'b0, d);
    endtask
    // Requests alternate valid/invalid while busy; none may produce read_valid or addr_err.
    task automatic busy_phase();
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b1, i[1], i[0] ? 32'd2 : 32'd4, W, 1'b0, 32'hDEAD_0000, 1'b1, 1'b0, 32'h2);
    endtask
    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 32'd4, W, 1'b0, 32'd0, 1'b1, 1'b0, 32'h2);
    endtask
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            chk("read_valid", m.id, {31'd0, read_valid}, {31'd0, m.rv});
            chk("addr_err", m.id, {31'd0, addr_err}, {31'd0, m.err});
            chk("busy", m.id, {31'd0, busy}, {31'd0, m.bsy});
            chk("read_data", m.id, read_data, m.data);
        end
    end
    initial begin
        vec[0]  = '{1'b1, 1'b0, 32'd0,  W, 1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vec[1]  = '{1'b1, 1'b0, 32'd4,  W, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0002};
        vec[2]  = '{1'b1, 1'b0, 32'd8,  W, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0001};
        vec[3]  = '{1'b0, 1'b1, 32'd12, W, 1'b0, 32'h8001_7F02, 1'b0, 1'b0, 32'd0};
        vec[4]  = '{1'b1, 1'b0, 32'd12, B, 1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FF80};
        vec[5]  = '{1'b1, 1'b0, 32'd12, B, 1'b1, 32'd0, 1'b1, 1'b0, 32'h0000_0080};
        vec[6]  = '{1'b1, 1'b0, 32'd14, H, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_7F02};
        vec[7]  = '{1'b1, 1'b0, 32'd15, B, 1'b1, 32'd0, 1'b1, 1'b0, 32'h0000_0002};
        vec[8]  = '{1'b1, 1'b0, 32'd12, H, 1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_8001};
        vec[9]  = '{1'b0, 1'b1, 32'd17, B, 1'b0, 32'h0000_00AB, 1'b0, 1'b0, 32'd0};
        vec[10] = '{1'b0, 1'b1, 32'd18, H, 1'b0, 32'h0000_C0DE, 1'b0, 1'b0, 32'd0};
        vec[11] = '{1'b1, 1'b0, 32'd16, W, 1'b0, 32'd0, 1'b1, 1'b0, 32'h00AB_C0DE};
        vec[12] = '{1'b1, 1'b0, 32'd2,  W, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0};
        vec[13] = '{1'b0, 1'b1, 32'd63, H, 1'b0, 32'h0000_BEEF, 1'b0, 1'b1, 32'd0};
        vec[14] = '{1'b1, 1'b0, 32'd60, W, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0002};
        vec[15] = '{1'b1, 1'b0, 32'd0,  R, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0};
        vec[16] = '{1'b1, 1'b0, 32'd64, W, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0};
        vec[17] = '{1'b1, 1'b0, 32'd63, B, 1'b1, 32'd0, 1'b1, 1'b0, 32'h0000_0002};
        vec[18] = '{1'b1, 1'b0, 32'd64, B, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0};
        vec[19] = '{1'b1, 1'b0, 32'd62, H, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0000_0002};
        vec[20] = '{1'b1, 1'b1, 32'd20, W, 1'b0, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0002};
        vec[21] = '{1'b1, 1'b0, 32'd20, W, 1'b0, 32'd0, 1'b1, 1'b0, 32'h1234_5678};
        vec[22] = '{1'b0, 1'b0, 32'd0,  B, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0};
        vec[23] = '{1'b0, 1'b1, 32'hFFFF_FFFC, W, 1'b0, 32'h5555_5555, 1'b0, 1'b1, 32'd0};
        vec[24] = '{1'b1, 1'b0, 32'd0,  B, 1'b0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vec[25] = '{1'b0, 1'b1, 32'd4,  W, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0};
        reset_cycles(2);
        busy_phase();
        for (int i = 0; i < 26; i++)
            drive(1'b1, vec[i].rd, vec[i].wr, vec[i].addr, vec[i].sz, vec[i].lu, vec[i].wd,
                  vec[i].rv, vec[i].err, vec[i].data);
        rd_word(32'd4, 32'hDEAD_BEEF);
        reset_cycles(2);
        busy_phase();
        rd_word(32'd4, 32'h0000_0002);
        rd_word(32'd8, 32'h0000_0001);
        drive(1'b1, 1'b0, 1'b1, 32'd4, W, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'd60, W, 1'b0, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'd0);
        rd_word(32'd60, 32'h0BAD_0BAD);
        reset_cycles(2);
        while (init_left > 9)
            drive(1'b1, 1'b1, 1'b0, 32'd2, W, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0);
        reset_cycles(1);
        busy_phase();
        rd_word(32'd4, 32'h0000_0002);
        rd_word(32'd0, 32'hFFFF_FFFF);
        rd_word(32'd60, 32'h0000_0002);
        idle();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
